irq_ctrl: RTL and testbench

Interrupt source controller sitting directly upstream of the processor core. It synchronizes and debounces the raw board keys and buffers 32-bit words arriving from the Ethernet receive path. It arbitrates between the two sources and drives the core's `interrupt_key`, `interrupt_eth` and `interrupt_source_data` inputs. Each interrupt is held in service until the core acknowledges that it has read the data word with its RDI instruction.

---
 rtl/irq_ctrl_if.sv | 30 +++
 rtl/irq_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_irq_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Signal bundle between irq_ctrl, the board/Ethernet sources and the core.
// slave = the controller side, master = the surrounding environment.
interface irq_ctrl_if #(
    parameter int NUM_KEYS   = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_KEYS-1:0] key_n;
    logic                eth_valid;
    logic [31:0]         eth_data;
    logic                rdi_ack;
    logic                interrupt_key;
    logic                interrupt_eth;
    logic [31:0]         interrupt_source_data;
    logic                eth_overflow;
    logic [CNT_W-1:0]    fifo_count;

    modport slave (
        input  key_n, eth_valid, eth_data, rdi_ack,
        output interrupt_key, interrupt_eth, interrupt_source_data,
        output eth_overflow, fifo_count
    );

    modport master (
        output key_n, eth_valid, eth_data, rdi_ack,
        input  interrupt_key, interrupt_eth, interrupt_source_data,
        input  eth_overflow, fifo_count
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt source controller: key synchronise/debounce, Ethernet word FIFO, ETH-first arbiter.
// Optional feature macro: IRQ_KEY_DEBOUNCE_EN (debounce counters; when undefined keys pass straight through the synchronizer).
module irq_ctrl #(
    parameter int NUM_KEYS        = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic      clk,
    input  logic      rst_n,
    irq_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (NUM_KEYS < 1 || NUM_KEYS > 8) begin : g_bad_num_keys
        $error("irq_ctrl: NUM_KEYS must be 1..8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("irq_ctrl: FIFO_DEPTH must be a power of two >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("irq_ctrl: DEBOUNCE_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                src_eth_q, src_eth_d;
    logic [NUM_KEYS-1:0] key_s1_q, key_s2_q;
    logic [NUM_KEYS-1:0] acc_q, acc_d;
    logic [NUM_KEYS-1:0] press_s;
    logic [NUM_KEYS-1:0] pend_q, pend_d;
    logic [31:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q;
    logic                full_s, push_s, pop_s, drop_s, fire_s;
    logic                irq_key_q, irq_key_d;
    logic                irq_eth_q, irq_eth_d;
    logic [31:0]         data_q, data_d;

    // Two-flop synchronizer for the asynchronous keys; idle level is released (1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q <= '1;
            key_s2_q <= '1;
        end else begin
            key_s1_q <= bus.key_n;
            key_s2_q <= key_s1_q;
        end
    end

`ifdef IRQ_KEY_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NUM_KEYS-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

    // Count cycles the synchronized level disagrees with the accepted one; agreement restarts the count
    always_comb begin
        acc_d    = acc_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_s2_q[i] == acc_q[i]) begin
                db_cnt_d[i] = {DB_W{1'b0}};
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES)) begin
                acc_d[i]    = key_s2_q[i];
                db_cnt_d[i] = {DB_W{1'b0}};
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Debounce counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_d;
        end
    end
`else
    // Without debounce the accepted level follows the synchronizer output
    always_comb begin
        acc_d = key_s2_q;
    end
`endif

    assign press_s = acc_q & ~acc_d;

    // Accepted key level register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '1;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Arbiter next state; a non-empty FIFO always wins over pending keys
    always_comb begin
        state_d   = state_q;
        src_eth_d = src_eth_q;
        case (state_q)
            IDLE: begin
                if (count_q != {CNT_W{1'b0}}) begin
                    state_d   = FIRE;
                    src_eth_d = 1'b1;
                end else if (pend_q != {NUM_KEYS{1'b0}}) begin
                    state_d   = FIRE;
                    src_eth_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            FIRE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.rdi_ack) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_eth_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_eth_q <= src_eth_d;
        end
    end

    assign full_s = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_s  = (state_q == WAIT_ACK) && src_eth_q && bus.rdi_ack;
    assign push_s = bus.eth_valid && (!full_s || pop_s);
    assign drop_s = bus.eth_valid && full_s && !pop_s;
    assign fire_s = (state_q == IDLE) && (state_d == FIRE);

    // Datapath next values: occupancy, pending keys and the registered interrupt outputs
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The key round clears what it reported; a press landing in FIRE survives through press_s
        if ((state_q == FIRE) && !src_eth_q) begin
            pend_d = press_s;
        end else begin
            pend_d = pend_q | press_s;
        end

        data_d    = data_q;
        irq_key_d = 1'b0;
        irq_eth_d = 1'b0;
        if (fire_s) begin
            irq_key_d = !src_eth_d;
            irq_eth_d = src_eth_d;
            if (src_eth_d) begin
                data_d = mem_q[rd_ptr_q];
            end else begin
                data_d = {{(32 - NUM_KEYS){1'b0}}, pend_d};
            end
        end else begin
            data_d = data_q;
        end
    end

    // Circular FIFO storage, pointers and the sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= bus.eth_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_q | drop_s;
        end
    end

    // Pending keys and registered interrupt outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= {NUM_KEYS{1'b0}};
            irq_key_q <= 1'b0;
            irq_eth_q <= 1'b0;
            data_q    <= 32'h0;
        end else begin
            pend_q    <= pend_d;
            irq_key_q <= irq_key_d;
            irq_eth_q <= irq_eth_d;
            data_q    <= data_d;
        end
    end

    assign bus.interrupt_key         = irq_key_q;
    assign bus.interrupt_eth         = irq_eth_q;
    assign bus.interrupt_source_data = data_q;
    assign bus.eth_overflow          = ovf_q;
    assign bus.fifo_count            = count_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
module tb_irq_ctrl;
    localparam int NK = 4;
    localparam int FD = 4;
    localparam int DB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    irq_ctrl_if #(.NUM_KEYS(NK), .FIFO_DEPTH(FD)) bus ();

    irq_ctrl #(.NUM_KEYS(NK), .FIFO_DEPTH(FD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int key_cnt  = 0;
    int eth_cnt  = 0;
    logic [31:0] key_last = 32'h0;
    logic [31:0] eth_log [0:31];

    // Pulse monitor: counts interrupt pulses and records their payloads
    always @(negedge clk) begin
        if (bus.interrupt_key) begin
            key_cnt  <= key_cnt + 1;
            key_last <= bus.interrupt_source_data;
        end
        if (bus.interrupt_eth) begin
            eth_log[eth_cnt % 32] <= bus.interrupt_source_data;
            eth_cnt <= eth_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic ack();
        bus.rdi_ack = 1'b1;
        tick(1);
        bus.rdi_ack = 1'b0;
    endtask

    task automatic wait_eth(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (eth_cnt > target) ok = 1'b1;
            else tick(1);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.key_n     = 4'hF;
        bus.eth_valid = 1'b0;
        bus.eth_data  = 32'h0;
        bus.rdi_ack   = 1'b0;
        tick(3);
        n_checks++; if (bus.interrupt_key !== 1'b0) begin n_fail++; $display("FAIL reset_irq_key: got %0b want 0", bus.interrupt_key); end
        n_checks++; if (bus.interrupt_eth !== 1'b0) begin n_fail++; $display("FAIL reset_irq_eth: got %0b want 0", bus.interrupt_eth); end
        n_checks++; if (bus.interrupt_source_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.interrupt_source_data); end
        n_checks++; if (bus.eth_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", bus.eth_overflow); end
        n_checks++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_key_press();
        int base = key_cnt;
        bus.key_n = 4'b1101;
        tick(10);
        n_checks++; if (key_cnt - base !== 1) begin n_fail++; $display("FAIL key_press_pulses: got %0d want 1", key_cnt - base); end
        n_checks++; if (key_last !== 32'h2) begin n_fail++; $display("FAIL key_press_payload: got %h want 2", key_last); end
        n_checks++; if (bus.interrupt_key !== 1'b0) begin n_fail++; $display("FAIL key_press_one_cycle: got %0b want 0", bus.interrupt_key); end
        bus.key_n = 4'hF;
        tick(8);
        n_checks++; if (bus.interrupt_source_data !== 32'h2) begin n_fail++; $display("FAIL key_press_hold: got %h want 2", bus.interrupt_source_data); end
        ack();
        tick(15);
        n_checks++; if (key_cnt - base !== 1) begin n_fail++; $display("FAIL key_press_after_ack: got %0d want 1", key_cnt - base); end
        n_checks++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL key_press_count: got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_key_bounce();
        int base = key_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.key_n = (i % 2 == 0) ? 4'b1110 : 4'b1111;
            tick(2);
        end
        bus.key_n = 4'hF;
        tick(20);
        repeat (4) begin
            ack();
            tick(3);
        end
`ifdef IRQ_KEY_DEBOUNCE_EN
        n_checks++; if (key_cnt - base !== 0) begin n_fail++; $display("FAIL key_bounce_pulses: got %0d want 0", key_cnt - base); end
`else
        n_checks++; if (key_cnt - base == 0) begin n_fail++; $display("FAIL key_bounce_pulses: got 0 want >0 (no debounce)"); end
`endif
    endtask

    task automatic test_eth_burst();
        int base = eth_cnt;
        bit ok;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hA1; exp_w[1] = 32'hA2; exp_w[2] = 32'hA3;
        bus.eth_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.eth_data = exp_w[i];
            tick(1);
        end
        bus.eth_valid = 1'b0;
        n_checks++; if (bus.fifo_count !== 3'd3) begin n_fail++; $display("FAIL burst_count_full: got %0d want 3", bus.fifo_count); end
        for (int k = 0; k < 3; k++) begin
            wait_eth(base + k, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL burst_timeout_%0d: got no pulse want pulse", k); end
            n_checks++; if (eth_log[(base + k) % 32] !== exp_w[k]) begin n_fail++; $display("FAIL burst_payload_%0d: got %h want %h", k, eth_log[(base + k) % 32], exp_w[k]); end
            n_checks++; if (bus.fifo_count !== 3'(3 - k)) begin n_fail++; $display("FAIL burst_count_pre_%0d: got %0d want %0d", k, bus.fifo_count, 3 - k); end
            tick(1);
            ack();
            n_checks++; if (bus.fifo_count !== 3'(2 - k)) begin n_fail++; $display("FAIL burst_count_post_%0d: got %0d want %0d", k, bus.fifo_count, 2 - k); end
        end
        tick(5);
    endtask

    task automatic test_overflow();
        int base = eth_cnt;
        bit ok;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'hB2; exp_w[1] = 32'hB3; exp_w[2] = 32'hB4; exp_w[3] = 32'hB6;
        bus.eth_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.eth_data = 32'hB0 + 32'(i);
            tick(1);
        end
        bus.eth_valid = 1'b0;
        n_checks++; if (bus.eth_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", bus.eth_overflow); end
        n_checks++; if (bus.fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", bus.fifo_count); end
        n_checks++; if (eth_cnt - base !== 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 1", eth_cnt - base); end
        n_checks++; if (eth_log[base % 32] !== 32'hB1) begin n_fail++; $display("FAIL ovf_first_payload: got %h want b1", eth_log[base % 32]); end
        bus.eth_valid = 1'b1;
        bus.eth_data  = 32'hB6;
        bus.rdi_ack   = 1'b1;
        tick(1);
        bus.eth_valid = 1'b0;
        bus.rdi_ack   = 1'b0;
        n_checks++; if (bus.fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_push_pop_count: got %0d want 4", bus.fifo_count); end
        n_checks++; if (bus.eth_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", bus.eth_overflow); end
        for (int k = 0; k < 4; k++) begin
            wait_eth(base + 1 + k, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_drain_timeout_%0d: got no pulse want pulse", k); end
            n_checks++; if (eth_log[(base + 1 + k) % 32] !== exp_w[k]) begin n_fail++; $display("FAIL ovf_drain_payload_%0d: got %h want %h", k, eth_log[(base + 1 + k) % 32], exp_w[k]); end
            tick(1);
            ack();
        end
        tick(3);
        n_checks++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL ovf_drained_count: got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_priority();
        int ebase = eth_cnt;
        int kbase = key_cnt;
        bit ok;
        bus.eth_valid = 1'b1;
        bus.eth_data  = 32'hC0;
        tick(1);
        bus.eth_valid = 1'b0;
        wait_eth(ebase, ok);
        tick(1);
        bus.key_n = 4'b1110;
        tick(10);
        bus.key_n     = 4'hF;
        bus.eth_valid = 1'b1;
        bus.eth_data  = 32'hC1;
        tick(1);
        bus.eth_valid = 1'b0;
        tick(3);
        n_checks++; if (key_cnt - kbase !== 0) begin n_fail++; $display("FAIL prio_key_blocked: got %0d want 0", key_cnt - kbase); end
        n_checks++; if (bus.fifo_count !== 3'd2) begin n_fail++; $display("FAIL prio_count: got %0d want 2", bus.fifo_count); end
        ack();
        wait_eth(ebase + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL prio_eth_timeout: got no pulse want pulse"); end
        n_checks++; if (eth_log[(ebase + 1) % 32] !== 32'hC1) begin n_fail++; $display("FAIL prio_eth_payload: got %h want c1", eth_log[(ebase + 1) % 32]); end
        n_checks++; if (key_cnt - kbase !== 0) begin n_fail++; $display("FAIL prio_eth_first: got %0d key pulses want 0", key_cnt - kbase); end
        tick(1);
        bus.rdi_ack = 1'b1;
        tick(1);
        bus.rdi_ack = 1'b0;
        n_checks++; if (bus.interrupt_key !== 1'b0) begin n_fail++; $display("FAIL prio_key_too_early: got %0b want 0", bus.interrupt_key); end
        tick(1);
        n_checks++; if (bus.interrupt_key !== 1'b1) begin n_fail++; $display("FAIL prio_key_fire: got %0b want 1", bus.interrupt_key); end
        n_checks++; if (bus.interrupt_source_data !== 32'h1) begin n_fail++; $display("FAIL prio_key_payload: got %h want 1", bus.interrupt_source_data); end
        tick(1);
        ack();
        tick(3);
    endtask

    task automatic test_reset_mid();
        int ebase;
        int kbase;
        bit ok;
        ebase = eth_cnt;
        bus.eth_valid = 1'b1;
        bus.eth_data  = 32'hD1;
        tick(1);
        bus.eth_data  = 32'hD2;
        tick(1);
        bus.eth_valid = 1'b0;
        wait_eth(ebase, ok);
        tick(1);
        n_checks++; if (bus.fifo_count !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre_count: got %0d want 2", bus.fifo_count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.interrupt_key !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq_key: got %0b want 0", bus.interrupt_key); end
        n_checks++; if (bus.interrupt_eth !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq_eth: got %0b want 0", bus.interrupt_eth); end
        n_checks++; if (bus.interrupt_source_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", bus.interrupt_source_data); end
        n_checks++; if (bus.eth_overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf: got %0b want 0", bus.eth_overflow); end
        n_checks++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", bus.fifo_count); end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        ebase = eth_cnt;
        kbase = key_cnt;
        tick(20);
        n_checks++; if (eth_cnt - ebase !== 0) begin n_fail++; $display("FAIL rstmid_no_eth: got %0d want 0", eth_cnt - ebase); end
        n_checks++; if (key_cnt - kbase !== 0) begin n_fail++; $display("FAIL rstmid_no_key: got %0d want 0", key_cnt - kbase); end
    endtask

    initial begin
        test_reset();
        test_key_press();
        test_key_bounce();
        test_eth_burst();
        test_overflow();
        test_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
